// File: rtl/processor_core_if.sv
// processor_core_if: operand/result bundle for the packed-SIMD add/sub unit.
// The master drives operands; the slave (the unit) returns registered results.
interface processor_core_if #(
  parameter int WORDSIZE = 64,
  parameter int SIZE     = 32
);
  localparam int LANES = WORDSIZE / SIZE;

  logic                in_valid;
  logic [WORDSIZE-1:0] num1;
  logic [WORDSIZE-1:0] num2;
  logic                operation_in;
  logic [WORDSIZE-1:0] result;
  logic                out_valid;
  logic [LANES-1:0]    carry_out;

  modport master (
    output in_valid,
    output num1,
    output num2,
    output operation_in,
    input  result,
    input  out_valid,
    input  carry_out
  );

  modport slave (
    input  in_valid,
    input  num1,
    input  num2,
    input  operation_in,
    output result,
    output out_valid,
    output carry_out
  );
endinterface

// File: rtl/processor_core.sv
// processor_core: registered packed-SIMD unsigned add/subtract, 1-cycle latency.
// Optional macro PROCESSOR_SAT_EN enables per-lane unsigned saturation.
module processor_core #(
  parameter int WORDSIZE = 64,
  parameter int SIZE     = 32
) (
  input logic               clk,
  input logic               rst,
  processor_core_if.slave   bus
);
  localparam int LANES = WORDSIZE / SIZE;

  logic [WORDSIZE-1:0] result_d, result_q;
  logic [LANES-1:0]    carry_d, carry_q;
  logic                valid_q;

  // Each lane computes on SIZE+1 bits; the top bit is carry or borrow.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [SIZE:0] a;
    logic [SIZE:0] b;
    logic [SIZE:0] s;

    assign a = {1'b0, bus.num1[i*SIZE +: SIZE]};
    assign b = {1'b0, bus.num2[i*SIZE +: SIZE]};
    assign s = bus.operation_in ? (a - b) : (a + b);
    assign carry_d[i] = s[SIZE];

`ifdef PROCESSOR_SAT_EN
    logic [SIZE-1:0] sat;
    assign sat = bus.operation_in ? {SIZE{1'b0}}
                                  : {SIZE{1'b1}};
    assign result_d[i*SIZE +: SIZE] = s[SIZE] ? sat
                                              : s[SIZE-1:0];
`else
    assign result_d[i*SIZE +: SIZE] = s[SIZE-1:0];
`endif
  end

  // Data registers load only on in_valid so idle operands never leak in.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      carry_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        result_q <= result_d;
        carry_q  <= carry_d;
      end
    end
  end

  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_processor_core.sv
// tb_processor_core: scoreboard bench for processor_core (64-bit, 2x32 lanes).
// Directed vectors; a negedge monitor pops expected results on out_valid.
module tb_processor_core;
  logic clk;
  logic rst;

  processor_core_if #(.WORDSIZE(64), .SIZE(32)) bus ();

  processor_core #(.WORDSIZE(64), .SIZE(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] r;
    logic [1:0]  c;
  } exp_t;

  exp_t sb[$];
  int   n_chk;
  int   n_fail;

  function automatic void chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h",
               name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got 1 expected 0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", bus.result, e.r);
        chk("sb_carry", {62'd0, bus.carry_out}, {62'd0, e.c});
      end
    end
  end

  task automatic issue(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        op,
    input logic [63:0] er,
    input logic [1:0]  ec
  );
    exp_t e;
    bus.in_valid     = 1'b1;
    bus.num1         = a;
    bus.num2         = b;
    bus.operation_in = op;
    e.r = er;
    e.c = ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid     = 1'b0;
    bus.num1         = 'x;
    bus.num2         = 'x;
    bus.operation_in = 1'bx;
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] ONES32 = 64'h0000_0000_FFFF_FFFF;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.in_valid     = 1'b0;
    bus.num1         = '0;
    bus.num2         = '0;
    bus.operation_in = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_carry", {62'd0, bus.carry_out}, 64'd0);
    chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("idle_valid", {63'd0, bus.out_valid}, 64'd0);

    issue(64'h5, 64'h2, 1'b0, 64'h7, 2'b00);
    issue(64'h5_000A, 64'h2, 1'b0, 64'h5_000C, 2'b00);
    issue(64'h0000_0000_0001_0005, 64'h0000_0002_0000_0000,
          1'b0, 64'h0000_0002_0001_0005, 2'b00);
    idle();
    @(negedge clk);
    chk("hold_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("hold_result", bus.result, 64'h0000_0002_0001_0005);
    idle();
    @(negedge clk);
    chk("hold_x_result", bus.result, 64'h0000_0002_0001_0005);

`ifdef PROCESSOR_SAT_EN
    issue(ONES32, 64'h1, 1'b0, ONES32, 2'b01);
    issue(64'h0, 64'h1, 1'b1, 64'h0, 2'b01);
    issue(64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000,
          1'b0, 64'hFFFF_FFFF_0000_0000, 2'b10);
    issue(64'h0000_0003_0000_0001, 64'h0000_0005_0000_0001,
          1'b1, 64'h0, 2'b10);
`else
    issue(ONES32, 64'h1, 1'b0, 64'h0, 2'b01);
    issue(64'h0, 64'h1, 1'b1, ONES32, 2'b01);
    issue(64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000,
          1'b0, 64'h0, 2'b10);
    issue(64'h0000_0003_0000_0001, 64'h0000_0005_0000_0001,
          1'b1, 64'hFFFF_FFFE_0000_0000, 2'b10);
`endif
    issue(64'h5, 64'h2, 1'b1, 64'h3, 2'b00);

    issue(64'h1, 64'h1, 1'b0, 64'h2, 2'b00);
    issue(64'h10, 64'h20, 1'b0, 64'h30, 2'b00);
    issue(64'h100, 64'h1, 1'b1, 64'hFF, 2'b00);
    idle();
    idle();

    rst              = 1'b1;
    bus.in_valid     = 1'b1;
    bus.num1         = 64'h1234;
    bus.num2         = 64'h1;
    bus.operation_in = 1'b0;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("midrst_result", bus.result, 64'd0);
    chk("midrst_carry", {62'd0, bus.carry_out}, 64'd0);

    repeat (3) idle();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0",
               sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/processor_core.md
Name: processor_core

Overview:
- Registered packed-SIMD integer add/subtract unit for the datapath.
- Two WORDSIZE-bit operands are split into lanes of SIZE bits.
- Each lane is added or subtracted independently; carries/borrows never cross lane boundaries.
- One-cycle latency with valid qualification; sits between the register file read ports and writeback.

Parameters:
- WORDSIZE, 64, operand/result width in bits.
- SIZE, 32, lane width in bits. WORDSIZE must be an integer multiple of SIZE. SIZE == WORDSIZE gives one full-width lane.
- LANES, WORDSIZE/SIZE, derived localparam; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands/operation valid this cycle
- num1  input  WORDSIZE  first operand (packed lanes, lane 0 = bits SIZE-1:0)
- num2  input  WORDSIZE  second operand (same packing)
- operation_in  input  1  0 = add (num1+num2), 1 = subtract (num1-num2)
- result  output  WORDSIZE  registered packed lane results
- out_valid  output  1  result/carry_out valid
- carry_out  output  LANES  per-lane carry (add) or borrow (subtract)

Behaviour:
- Reset: on a rising clk with rst=1, result=0, carry_out=0 and out_valid=0. Reset overrides in_valid.
- Accepting an operation: on a rising clk with rst=0 and in_valid=1:
  - For each lane i, compute on SIZE+1 bits: a = num1 lane i, b = num2 lane i.
  - Add: {c,s} = a + b; carry_out[i] = c.
  - Subtract: s = a - b modulo 2^SIZE; carry_out[i] = 1 when a < b (unsigned borrow).
  - result lane i = s.
  - out_valid = 1 on the next cycle.
- Latency: exactly 1 cycle. Operands sampled at edge N appear on result at edge N (visible after edge N, i.e. during cycle N+1).
- No backpressure. A new operation is accepted every cycle; back-to-back in_valid produces back-to-back out_valid.
- in_valid=0 (rst=0): out_valid goes to 0. result and carry_out hold their last values.
- Arithmetic is unsigned modulo 2^SIZE per lane; no signed overflow flag.
- Lane isolation: lane overflow wraps within the lane. The adjacent lane is unaffected, e.g. lane0 0xFFFFFFFF+1 gives lane0 0 and leaves lane1 unchanged.
- Reset mid-stream: an operation presented in the same cycle as rst=1 is discarded, with no out_valid.
- operation_in is sampled only with in_valid=1.
- X on operands with in_valid=0 must not propagate to result.

Optional Feature:
- Macro: PROCESSOR_SAT_EN.
- Defined: per-lane unsigned saturation.
  - An add that carries yields lane = all ones (2^SIZE-1).
  - A subtract that borrows yields lane = 0.
  - carry_out still reports the raw carry/borrow, so it serves as a saturation indicator.
- Undefined: modulo wrap-around as described above; no saturation logic synthesized.

Test Plan:
- Reset: rst=1 for 2 cycles -> result=0, carry_out=0, out_valid=0. Release, no in_valid -> out_valid stays 0.
- Add, lane 0 only: num1=0x0000_0000_0000_0005, num2=0x0000_0000_0000_0002, op=0 -> next cycle result=0x0000_0000_0000_0007, carry_out=0, out_valid=1.
- Add, mixed values:
  - num1=0x0000_0000_0005_000A, num2=0x2, op=0 -> result=0x0000_0000_0005_000C.
  - num1=0x0000_0000_0001_0005, num2=0x0000_0002_0000_0000, op=0 -> result=0x0000_0002_0001_0005.
- Lane isolation/carry: num1=0x0000_0000_FFFF_FFFF, num2=0x1, add -> result=0x0000_0000_0000_0000, carry_out=2'b01. With PROCESSOR_SAT_EN: result=0x0000_0000_FFFF_FFFF.
- Subtract/borrow:
  - num1=0x5, num2=0x2, op=1 -> result=0x3, carry_out=0.
  - num1=0x0, num2=0x1, op=1 -> result=0x0000_0000_FFFF_FFFF, carry_out=2'b01. With PROCESSOR_SAT_EN: result=0.
- Streaming and reset mid-operation:
  - Three back-to-back in_valid cycles -> three consecutive out_valid cycles with matching results.
  - Assert rst together with an in_valid -> out_valid=0 and result=0 the next cycle.
